// File: rtl/tmd_fetch_pc_gen.sv
// Fetch PC sequencer: drives the BTB with the current PC, issues credit-limited
// instruction fetches and returns {pc, inst} in order; flushes drain stale responses.
module tmd_fetch_pc_gen #(
  localparam int          XLEN     = 64,  // mirrors rv64g_pkg::XLEN
  parameter  logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter  int          DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            srst_i,
  output logic [XLEN-1:0] btb_pc_o,
  input  logic [XLEN-1:0] btb_next_pc_i,
  input  logic            btb_clear_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fetch_req_valid_o,
  input  logic            fetch_req_ready_i,
  output logic [XLEN-1:0] fetch_req_addr_o,
  input  logic            fetch_rsp_valid_i,
  input  logic [31:0]     fetch_rsp_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]     DEPTH_W    = DEPTH[CW:0];
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic            flush;
  logic [XLEN-1:0] flush_target;
  logic [CW:0]     occupancy;
  logic            has_credit;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  logic [PW-1:0]   fill_ptr;

  assign flush        = redirect_valid_i | btb_clear_i;
  assign flush_target = redirect_valid_i ? redirect_pc_i : btb_next_pc_i;
  assign occupancy    = {1'b0, outstanding_q} + {1'b0, count_q};
  assign has_credit   = occupancy < DEPTH_W;

  assign btb_pc_o         = pc_q & ALIGN_MASK;
  assign fetch_req_addr_o = pc_q & ALIGN_MASK;

  // Responses return in request order, so the oldest unfilled slot sits right
  // after the buffered instructions.
  assign fill_ptr = rd_ptr_q + count_q[PW-1:0];

  assign req_fire = fetch_req_valid_o & fetch_req_ready_i;
  assign rsp_keep = fetch_rsp_valid_i & (state_q == RUN) & ~flush;
  assign pop      = inst_valid_o & inst_ready_i & ~flush;

  assign inst_o    = inst_mem[rd_ptr_q];
  assign inst_pc_o = pc_mem[rd_ptr_q];

  // State register
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (flush && (outstanding_d != '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    fetch_req_valid_o = 1'b0;
    inst_valid_o      = 1'b0;
    if (!srst_i) begin
      fetch_req_valid_o = (state_q == RUN) & has_credit & ~flush;
      inst_valid_o      = (count_q != '0);
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = flush_target & ALIGN_MASK;
    end else if (req_fire) begin
      pc_d = btb_next_pc_i & ALIGN_MASK;
    end
  end

  // Stale responses still return a credit even though their data is discarded.
  always_comb begin
    outstanding_d = outstanding_q;
    if (req_fire && !fetch_rsp_valid_i) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!req_fire && fetch_rsp_valid_i) begin
      outstanding_d = outstanding_q - CW'(1);
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (rsp_keep && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!rsp_keep && pop) begin
        count_d = count_q - CW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (req_fire) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pc_q          <= RESET_PC & ALIGN_MASK;
      outstanding_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // The slot's PC is written when the request is accepted, its instruction
  // when the matching response comes back.
  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      pc_mem[wr_ptr_q] <= pc_q & ALIGN_MASK;
    end
    if (rsp_keep) begin
      inst_mem[fill_ptr] <= fetch_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_tmd_fetch_pc_gen.sv
// Directed bench for tmd_fetch_pc_gen with a latency-configurable memory model
// and an in-order scoreboard of expected {pc, inst} pairs.
module tb_tmd_fetch_pc_gen;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h1000;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic [63:0] btb_pc_o;
  logic [63:0] btb_next_pc_i;
  logic        btb_clear_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        fetch_req_valid_o;
  logic        fetch_req_ready_i;
  logic [63:0] fetch_req_addr_o;
  logic        fetch_rsp_valid_i;
  logic [31:0] fetch_rsp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;

  logic        btb_ovr_en;
  logic [63:0] btb_ovr_pc;

  always #5 clk_i = ~clk_i;

  // BTB stand-in: sequential prediction unless the bench overrides it.
  assign btb_next_pc_i = btb_ovr_en ? btb_ovr_pc : btb_pc_o + 64'd4;

  tmd_fetch_pc_gen #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .btb_pc_o         (btb_pc_o),
    .btb_next_pc_i    (btb_next_pc_i),
    .btb_clear_i      (btb_clear_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .fetch_req_valid_o(fetch_req_valid_o),
    .fetch_req_ready_i(fetch_req_ready_i),
    .fetch_req_addr_o (fetch_req_addr_o),
    .fetch_rsp_valid_i(fetch_rsp_valid_i),
    .fetch_rsp_data_i (fetch_rsp_data_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  mem_req_t    mem_q[$];
  exp_t        exp_q[$];
  int          cyc;
  int          mem_lat;
  int          vectors;
  int          miscompares;
  int          n_req;
  int          n_pop;
  logic [63:0] exp_req_addr;
  logic        obs_req_valid;
  logic        obs_inst_valid;
  logic [63:0] obs_addr;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory response, sample outputs mid-cycle,
  // update the models, then advance past the next rising edge.
  task automatic step();
    mem_req_t m;
    exp_t     e;
    logic     flush;
    fetch_rsp_valid_i = 1'b0;
    fetch_rsp_data_i  = 32'h0;
    if (!srst_i && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      fetch_rsp_valid_i = 1'b1;
      fetch_rsp_data_i  = mem_data(m.addr);
    end
    #1;
    obs_req_valid  = fetch_req_valid_o;
    obs_inst_valid = inst_valid_o;
    obs_addr       = fetch_req_addr_o;
    flush          = redirect_valid_i | btb_clear_i;
    if (srst_i) begin
      check("rst_req_valid", 64'(fetch_req_valid_o), 64'd0);
      check("rst_inst_valid", 64'(inst_valid_o), 64'd0);
      mem_q.delete();
      exp_q.delete();
      exp_req_addr = RESET_PC & ~64'h3;
    end else begin
      check("occupancy_le_depth",
            64'((int'(dut.outstanding_q) + int'(dut.count_q)) <= DEPTH), 64'd1);
      if (flush) begin
        check("flush_req_valid", 64'(fetch_req_valid_o), 64'd0);
        exp_q.delete();
        exp_req_addr = (redirect_valid_i ? redirect_pc_i : btb_next_pc_i) & ~64'h3;
      end else begin
        if (inst_valid_o && inst_ready_i) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            check("pop_unexpected", 64'(inst_valid_o), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("inst_pc", inst_pc_o, e.pc);
            check("inst_data", 64'(inst_o), 64'(e.inst));
          end
        end
        if (fetch_req_valid_o && fetch_req_ready_i) begin
          n_req++;
          check("req_addr", fetch_req_addr_o, exp_req_addr);
          m.addr = fetch_req_addr_o;
          m.due  = cyc + mem_lat;
          mem_q.push_back(m);
          e.pc   = exp_req_addr;
          e.inst = mem_data(exp_req_addr);
          exp_q.push_back(e);
          exp_req_addr = btb_ovr_en ? (btb_ovr_pc & ~64'h3) : exp_req_addr + 64'd4;
        end
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    srst_i = 1'b1;
    step();
    step();
    srst_i = 1'b0;
  endtask

  initial begin
    srst_i            = 1'b1;
    btb_clear_i       = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_pc_i     = 64'h0;
    fetch_req_ready_i = 1'b1;
    fetch_rsp_valid_i = 1'b0;
    fetch_rsp_data_i  = 32'h0;
    inst_ready_i      = 1'b1;
    btb_ovr_en        = 1'b0;
    btb_ovr_pc        = 64'h0;
    mem_lat           = 1;
    cyc               = 0;
    vectors           = 0;
    miscompares       = 0;
    n_req             = 0;
    n_pop             = 0;
    exp_req_addr      = RESET_PC;

    // Reset and sequential fetch at full rate
    do_reset();
    step();
    check("first_req_valid", 64'(obs_req_valid), 64'd1);
    check("first_req_addr", obs_addr, 64'h1000);
    repeat (3) step();
    n_pop = 0;
    repeat (10) step();
    check("throughput_pops", 64'(n_pop), 64'd10);

    // Decode backpressure: only DEPTH requests may be accepted
    inst_ready_i = 1'b0;
    do_reset();
    n_req = 0;
    repeat (10) step();
    check("bp_req_count", 64'(n_req), 64'(DEPTH));
    check("bp_req_valid_off", 64'(obs_req_valid), 64'd0);
    check("bp_inst_valid", 64'(obs_inst_valid), 64'd1);
    inst_ready_i = 1'b1;
    repeat (8) step();
    fetch_req_ready_i = 1'b0;
    repeat (6) step();
    check("bp_drained_inst_valid", 64'(obs_inst_valid), 64'd0);
    check("bp_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    fetch_req_ready_i = 1'b1;

    // BTB clear with two requests in flight
    mem_lat = 3;
    do_reset();
    step();
    step();
    btb_clear_i = 1'b1;
    btb_ovr_en  = 1'b1;
    btb_ovr_pc  = 64'h2000;
    step();
    btb_clear_i = 1'b0;
    btb_ovr_en  = 1'b0;
    step();
    check("clr_stale1_req_valid", 64'(obs_req_valid), 64'd0);
    check("clr_stale1_addr", obs_addr, 64'h2000);
    check("clr_stale1_inst_valid", 64'(obs_inst_valid), 64'd0);
    step();
    check("clr_stale2_req_valid", 64'(obs_req_valid), 64'd0);
    check("clr_stale2_inst_valid", 64'(obs_inst_valid), 64'd0);
    step();
    check("clr_refetch_valid", 64'(obs_req_valid), 64'd1);
    check("clr_refetch_addr", obs_addr, 64'h2000);

    // Redirect and clear together, with a response and a pop in the same cycle
    mem_lat = 1;
    do_reset();
    repeat (6) step();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h3000;
    btb_clear_i      = 1'b1;
    btb_ovr_en       = 1'b1;
    btb_ovr_pc       = 64'h2000;
    step();
    check("sim_inst_valid_pre", 64'(obs_inst_valid), 64'd1);
    redirect_valid_i = 1'b0;
    btb_clear_i      = 1'b0;
    btb_ovr_en       = 1'b0;
    check("sim_pc", btb_pc_o, 64'h3000);
    check("sim_outstanding", 64'(dut.outstanding_q), 64'(mem_q.size()));
    check("sim_fifo_empty", 64'(inst_valid_o), 64'd0);
    step();
    check("sim_refetch_valid", 64'(obs_req_valid), 64'd1);
    check("sim_refetch_addr", obs_addr, 64'h3000);

    // Misaligned redirect target
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h4006;
    step();
    redirect_valid_i = 1'b0;
    check("misalign_pc", fetch_req_addr_o, 64'h4004);
    step();
    check("misalign_req_addr", obs_addr, 64'h4004);

    // Reset while draining stale responses
    mem_lat = 3;
    do_reset();
    repeat (3) step();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h5000;
    step();
    redirect_valid_i = 1'b0;
    step();
    check("rmf_in_drain", 64'(obs_req_valid), 64'd0);
    srst_i = 1'b1;
    step();
    check("rmf_pc", btb_pc_o, RESET_PC);
    check("rmf_outstanding", 64'(dut.outstanding_q), 64'd0);
    check("rmf_count", 64'(dut.count_q), 64'd0);
    srst_i = 1'b0;
    step();
    check("rmf_run_valid", 64'(obs_req_valid), 64'd1);
    check("rmf_run_addr", obs_addr, RESET_PC);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
